// File: rtl/inst_fetch.sv
// Sequential instruction fetch: pc drives imem_addr, word registered to out_inst 1 cycle later.
// Backpressure: out_valid && !out_ready freezes pc/out regs; redirect flushes output; HALT_WORD parks fetch.
module inst_fetch #(
    parameter logic [11:0] RESET_PC  = 12'h000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redir_valid,
    input  logic [11:0] redir_target,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [11:0] out_pc,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [11:0] out_pc_q, out_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic advance;
    logic accept;

    assign advance = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept  = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        misalign_d  = redir_valid && (redir_target[1:0] != 2'b00);
        // A handshake in the redirect cycle still counts; only the output is flushed.
        fetch_cnt_d = fetch_cnt_q + {31'd0, accept};

        if (redir_valid) begin
            pc_d        = {redir_target[11:2], 2'b00};
            out_valid_d = 1'b0;
            state_d     = fetch_en ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) out_valid_d = 1'b0;
                    if (fetch_en) state_d = RUN;
                end
                RUN: begin
                    if (advance) begin
                        out_inst_d  = imem_inst;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + 12'd4;
                        if (imem_inst == HALT_WORD) state_d = HALT;
                        else if (!fetch_en)         state_d = IDLE;
                    end else begin
                        if (accept) out_valid_d = 1'b0;
                        if (!fetch_en) state_d = IDLE;
                    end
                end
                HALT: begin
                    if (accept) out_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_pc_q    <= 12'd0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign misalign  = misalign_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural instruction memory, scoreboard of expected accepted (pc, inst).
module tb_inst_fetch;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redir_valid;
    logic [11:0] redir_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [11:0] out_pc;
    logic        misalign;
    logic [31:0] fetch_cnt;

    logic [31:0] mem [1024];
    logic [43:0] sb_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.RESET_PC(12'h000), .HALT_WORD(HALT_W)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .misalign(misalign), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_addr[11:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] pc, input logic [31:0] inst);
        sb_q.push_back({pc, inst});
    endtask

    // Every handshake seen on the output must match the next scoreboard entry.
    always @(negedge clk) begin
        logic [43:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_accept_pc", {20'd0, out_pc}, 32'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("acc_pc",   {20'd0, out_pc}, {20'd0, e[43:32]});
                chk("acc_inst", out_inst, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[4] = HALT_W;

        rst = 1'b1; fetch_en = 1'b0; redir_valid = 1'b0; redir_target = 12'h0; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_imem_addr", {20'd0, imem_addr}, 32'h000);
        chk("rst_misalign",  {31'd0, misalign}, 32'd0);
        chk("rst_out_inst",  out_inst, 32'd0);
        chk("rst_out_pc",    {20'd0, out_pc}, 32'd0);

        // Three back-to-back words from reset
        push(12'h000, 32'h11); push(12'h004, 32'h22); push(12'h008, 32'h33);
        fetch_en = 1'b1; out_ready = 1'b1;
        step(1);
        chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
        step(1);
        chk("seq_inst0", out_inst, 32'h11);
        step(1);
        chk("seq_inst1", out_inst, 32'h22);
        fetch_en = 1'b0;
        step(1);
        chk("seq_inst2", out_inst, 32'h33);
        chk("seq_pc2", {20'd0, out_pc}, 32'h008);
        step(1);
        chk("seq_drained", {31'd0, out_valid}, 32'd0);
        chk("seq_cnt3", fetch_cnt, 32'd3);
        chk("idle_pc_hold", {20'd0, imem_addr}, 32'h00C);

        // Stall with 0x22 on the output
        redir_valid = 1'b1; redir_target = 12'h000; fetch_en = 1'b1; out_ready = 1'b0;
        step(1);
        redir_valid = 1'b0; out_ready = 1'b1;
        push(12'h000, 32'h11); push(12'h004, 32'h22);
        step(2);
        chk("stall_load", out_inst, 32'h22);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("stall_inst",  out_inst, 32'h22);
            chk("stall_pc",    {20'd0, out_pc}, 32'h004);
            chk("stall_addr",  {20'd0, imem_addr}, 32'h008);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
        chk("resume_inst", out_inst, 32'h33);
        chk("resume_pc", {20'd0, out_pc}, 32'h008);

        // Misaligned redirect while stalled
        redir_valid = 1'b1; redir_target = 12'h102;
        step(1);
        chk("redir_flush", {31'd0, out_valid}, 32'd0);
        chk("redir_misalign", {31'd0, misalign}, 32'd1);
        chk("redir_addr", {20'd0, imem_addr}, 32'h100);
        redir_valid = 1'b0; out_ready = 1'b1;
        push(12'h100, 32'hA000_0040);
        step(1);
        chk("redir_out_pc", {20'd0, out_pc}, 32'h100);
        chk("misalign_clear", {31'd0, misalign}, 32'd0);

        // Redirect coincident with a handshake, then wrap past 0xFFC into the halt word
        redir_valid = 1'b1; redir_target = 12'hFF8;
        step(1);
        redir_valid = 1'b0;
        chk("redir_hs_cnt", fetch_cnt, 32'd6);
        chk("redir_hs_flush", {31'd0, out_valid}, 32'd0);
        chk("aligned_no_mis", {31'd0, misalign}, 32'd0);
        push(12'hFF8, 32'hA000_03FE); push(12'hFFC, 32'hA000_03FF);
        push(12'h000, 32'h11); push(12'h004, 32'h22); push(12'h008, 32'h33);
        push(12'h00C, 32'hA000_0003); push(12'h010, HALT_W);
        step(2);
        chk("wrap_pc_ffc", {20'd0, out_pc}, 32'hFFC);
        step(1);
        chk("wrap_pc_000", {20'd0, out_pc}, 32'h000);
        step(4);
        chk("halt_pc", {20'd0, out_pc}, 32'h010);
        chk("halt_inst", out_inst, HALT_W);
        step(1);
        chk("halt_cnt", fetch_cnt, 32'd13);
        for (int c = 0; c < 4; c++) begin
            chk("halt_valid", {31'd0, out_valid}, 32'd0);
            chk("halt_addr", {20'd0, imem_addr}, 32'h014);
            if (c < 3) step(1);
        end
        redir_valid = 1'b1; redir_target = 12'h000;
        step(1);
        redir_valid = 1'b0; out_ready = 1'b0;
        step(1);
        chk("restart_inst", out_inst, 32'h11);
        chk("restart_pc", {20'd0, out_pc}, 32'h000);
        step(1);
        chk("restart_stall", {31'd0, out_valid}, 32'd1);

        // Reset in the middle of a stall
        rst = 1'b1;
        step(1);
        rst = 1'b0; fetch_en = 1'b0;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_cnt", fetch_cnt, 32'd0);
        chk("rst2_addr", {20'd0, imem_addr}, 32'h000);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 12'h000: byte address fetched first after reset.
REQ-002 Parameter HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fetch_en  input  1  permits fetch in IDLE and RUN.
REQ-006 redir_valid  input  1  one-cycle request to restart fetch at redir_target.
REQ-007 redir_target  input  12  byte address for redirect.
REQ-008 imem_addr  output  12  byte address to the instruction memory (combinational read, word index = addr>>2).
REQ-009 imem_inst  input  32  instruction word returned in the same cycle as imem_addr.
REQ-010 out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  decode accepts the instruction when out_valid && out_ready.
REQ-012 out_inst  output  32  registered instruction.
REQ-013 out_pc  output  12  byte address of out_inst.
REQ-014 misalign  output  1  one-cycle pulse: accepted redirect had redir_target[1:0] != 0.
REQ-015 fetch_cnt  output  32  number of instructions accepted by decode since reset.

Function
REQ-016 States: IDLE, RUN, HALT; pc register 12 bits; imem_addr SHALL equal pc combinationally.
REQ-017 IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 and no redirect; HALT exits only on redirect or reset.
REQ-018 advance = (state==RUN) && (!out_valid || out_ready).
REQ-019 On advance: out_inst <= imem_inst, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
REQ-020 Latency: instruction at pc SHALL appear on out_inst one clock after the cycle pc drives imem_addr.
REQ-021 pc increment SHALL wrap 12'hFFC -> 12'h000 with no flag.
REQ-022 Not advancing with out_valid && !out_ready: out_inst, out_pc, pc, out_valid SHALL hold unchanged.
REQ-023 Not advancing with out_valid && out_ready: out_valid <= 0; pc holds.
REQ-024 If imem_inst == HALT_WORD on an advance: the word SHALL be issued normally, pc <= pc + 4, state <= HALT.
REQ-025 redir_valid=1 (any state, priority over advance, stall, halt, fetch_en): pc <= {redir_target[11:2],2'b00}, out_valid <= 0, state <= RUN if fetch_en else IDLE; the instruction on imem_inst that cycle SHALL be discarded.
REQ-026 Redirect with out_valid && out_ready in the same cycle: the handshake SHALL complete (fetch_cnt increments), then output is flushed.
REQ-027 misalign SHALL be 1 exactly in the cycle after a redirect whose redir_target[1:0] != 0, otherwise 0.
REQ-028 fetch_cnt SHALL increment by 1 on each out_valid && out_ready cycle; wraps at 2^32.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 rst=1 at a clock edge: pc=RESET_PC, state=IDLE, out_valid=0, out_inst=0, out_pc=0, misalign=0, fetch_cnt=0.
REQ-031 rst SHALL override redirect, advance and halt in the same cycle; reset mid-stall discards the held instruction.
REQ-032 First fetch of RESET_PC occurs the cycle after fetch_en is seen high in IDLE.

Verification
REQ-033 Reset, fetch_en=1, out_ready=1, imem words 0x11,0x22,0x33 at 0x000/4/8 -> out_inst 0x11,0x22,0x33 on consecutive cycles, out_pc 0x000,0x004,0x008, fetch_cnt=3.
REQ-034 out_ready=0 for 3 cycles with out_valid=1, out_inst=0x22 -> out_inst, out_pc, pc stable for 3 cycles; resume with no loss or duplicate.
REQ-035 redir_valid=1, redir_target=0x102 while stalled -> next cycle out_valid=0, misalign=1, imem_addr=0x100; following cycle out_pc=0x100.
REQ-036 pc=0xFFC, sequential run -> out_pc 0xFFC then 0x000.
REQ-037 imem_inst=HALT_WORD at 0x010 -> issued with out_pc=0x010, then out_valid=0 and imem_addr stays 0x014 until redirect to 0x000 restarts fetch.
REQ-038 rst=1 during stall with out_valid=1 -> next cycle out_valid=0, fetch_cnt=0, imem_addr=RESET_PC.
